// File: rtl/sram_ws_model.sv
// Wait-state SRAM model: per-byte writable word store behind a strobe/ack bus with WAIT idle cycles per access.
// Define SRAM_WS_ERR_EN to answer addresses >= DEPTH with err_o; otherwise addresses wrap modulo DEPTH.
module sram_ws_model #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 2**AW,
  parameter int WAIT  = 0
) (
  input  logic            clk_i,
  input  logic            nrst_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            busy_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request is taken when cyc_i & stb_i are high at an edge in IDLE; exactly one
  // ack_o or err_o pulse follows WAIT+1 edges later unless cyc_i drops during WAIT or reset hits.
  localparam int NB = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            we_q, we_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic [DW-1:0]   lane_mask;
  logic [DW-1:0]   rd_word;
  logic            wr_en;
  logic [DW-1:0]   mem [DEPTH];

  function automatic logic [IW-1:0] to_idx(input logic [AW-1:0] a);
    return IW'({1'b0, a} % DEPTH_W);
  endfunction

  function automatic logic addr_bad(input logic [AW-1:0] a);
`ifdef SRAM_WS_ERR_EN
    return ({1'b0, a} >= DEPTH_W);
`else
    return 1'b0;
`endif
  endfunction

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NB; k++) lane_mask[8*k +: 8] = {8{sel_q[k]}};
  end

  assign rd_word = mem[to_idx(adr_q)];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          adr_d  = adr_i;
          we_d   = we_i;
          sel_d  = sel_i;
          wdat_d = dat_i;
          if (WAIT > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (addr_bad(adr_q)) begin
          err_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          if (!we_q) rdat_d = rd_word & lane_mask;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The write lands on the edge that enters RESP; the _d side holds the request for both entry paths.
  assign wr_en = nrst_i && (state_d == ST_RESP) && (state_q != ST_RESP) && we_d && !addr_bad(adr_d);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Storage is never reset so contents survive nrst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (sel_d[k]) mem[to_idx(adr_d)][8*k +: 8] <= wdat_d[8*k +: 8];
      end
    end
  end

  assign dat_o       = rdat_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
